wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 39 +++
 rtl/wb_stage_load_ext.sv | 41 ++++
 rtl/wb_stage.sv | 100 ++++++++++
 tb/tb_wb_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: width macros, load funct3 codes, MEM/WB register layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).

`ifndef WB_STAGE_DEFS_SVH
`define WB_STAGE_DEFS_SVH

`define RS_WIDTH        5
`define FUNCT3_WIDTH    3
`define REG_DATA_WIDTH  32

`define FUNCT3_LB       3'b000
`define FUNCT3_LH       3'b001
`define FUNCT3_LW       3'b010
`define FUNCT3_LBU      3'b100
`define FUNCT3_LHU      3'b101

`endif

package wb_stage_pkg;

    // Everything the MEM/WB pipeline register carries from MEM into WB.
    typedef struct packed {
        logic                         valid;
        logic                         regwrite;
        logic                         memtoreg;
        logic                         branchjalx;
        logic [`RS_WIDTH-1:0]         rd;
        logic [`FUNCT3_WIDTH-1:0]     funct3;
        logic [1:0]                   addr_lo;
        logic [`REG_DATA_WIDTH-1:0]   alu_result;
        logic [`REG_DATA_WIDTH-1:0]   pc_plus4;
        logic [`REG_DATA_WIDTH-1:0]   read_data;
    } wb_reg_t;

    // A bubble is the all-zero register: not valid, no write, zero data.
    localparam wb_reg_t WB_BUBBLE = '0;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: selects byte/halfword from an aligned word and sign/zero extends it by funct3.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.

module load_ext
    import wb_stage_pkg::*;
(
    input  logic [`FUNCT3_WIDTH-1:0]    funct3,
    input  logic [1:0]                  addr_lo,
    input  logic [`REG_DATA_WIDTH-1:0]  word,
    output logic [`REG_DATA_WIDTH-1:0]  data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword; halfword ignores addr_lo[0] (no misalignment handling here).
    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    // Extend according to load type; unknown codes fall back to a full word.
    always_comb begin
        data = word;
        case (funct3)
            `FUNCT3_LB:  data = {{(`REG_DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            `FUNCT3_LH:  data = {{(`REG_DATA_WIDTH-16){half_sel[15]}}, half_sel};
            `FUNCT3_LBU: data = {{(`REG_DATA_WIDTH-8){1'b0}}, byte_sel};
            `FUNCT3_LHU: data = {{(`REG_DATA_WIDTH-16){1'b0}}, half_sel};
            default:     data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register plus write-back mux; optional retired-instruction counter under WB_INSTRET_EN.
// Latency: one cycle from the capturing edge to the WB outputs; outputs depend only on registered state.
// Backpressure: stall holds the register, flush loads a bubble and wins over stall.

module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int INSTRET_WIDTH = 64
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        valid_mem,
    input  logic [`RS_WIDTH-1:0]        rd_mem,
    input  logic                        regwrite_mem,
    input  logic                        memtoreg_mem,
    input  logic                        branchjalx_mem,
    input  logic [`FUNCT3_WIDTH-1:0]    funct3_mem,
    input  logic [1:0]                  addr_lo_mem,
    input  logic [`REG_DATA_WIDTH-1:0]  alu_result_mem,
    input  logic [`REG_DATA_WIDTH-1:0]  pc_plus4_mem,
    input  logic [`REG_DATA_WIDTH-1:0]  read_data_mem,
    output logic [`RS_WIDTH-1:0]        rd_wb,
    output logic                        regwrite_wb,
    output logic [`REG_DATA_WIDTH-1:0]  write_data_wb
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_WIDTH-1:0]    instret
`endif
);

    wb_reg_t                     mem_d;
    wb_reg_t                     wb_q;
    logic [`REG_DATA_WIDTH-1:0]  load_data;

    // Bundle the MEM-stage inputs into the register layout.
    always_comb begin
        mem_d            = WB_BUBBLE;
        mem_d.valid      = valid_mem;
        mem_d.regwrite   = regwrite_mem;
        mem_d.memtoreg   = memtoreg_mem;
        mem_d.branchjalx = branchjalx_mem;
        mem_d.rd         = rd_mem;
        mem_d.funct3     = funct3_mem;
        mem_d.addr_lo    = addr_lo_mem;
        mem_d.alu_result = alu_result_mem;
        mem_d.pc_plus4   = pc_plus4_mem;
        mem_d.read_data  = read_data_mem;
    end

    // Pipeline register: flush beats stall, stall holds, otherwise capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= WB_BUBBLE;
        end else if (flush) begin
            wb_q <= WB_BUBBLE;
        end else if (!stall) begin
            wb_q <= mem_d;
        end
    end

    // Load extension works on the registered word so no MEM input reaches the outputs combinationally.
    load_ext u_load_ext (
        .funct3  (wb_q.funct3),
        .addr_lo (wb_q.addr_lo),
        .word    (wb_q.read_data),
        .data    (load_data)
    );

    assign rd_wb       = wb_q.rd;
    assign regwrite_wb = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);

    // Result select: link address first, then load data, then ALU result.
    always_comb begin
        write_data_wb = wb_q.alu_result;
        if (wb_q.branchjalx) begin
            write_data_wb = wb_q.pc_plus4;
        end else if (wb_q.memtoreg) begin
            write_data_wb = load_data;
        end
    end

`ifdef WB_INSTRET_EN
    logic [INSTRET_WIDTH-1:0] instret_q;

    // Count the occupant as retired when it leaves WB: a normal advance or a flush, not a plain stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (wb_q.valid && (!stall || flush)) begin
            instret_q <= instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed load/jal/stall cases, then randomized traffic vs a reference model.
// Latency: model expects outputs one edge after capture.
// Backpressure: stall/flush randomized and checked against hold/bubble rules.

module tb_wb_stage;

    localparam int IW = 4;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_mem;
    logic [4:0]  rd_mem;
    logic        regwrite_mem;
    logic        memtoreg_mem;
    logic        branchjalx_mem;
    logic [2:0]  funct3_mem;
    logic [1:0]  addr_lo_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] pc_plus4_mem;
    logic [31:0] read_data_mem;
    logic [4:0]  rd_wb;
    logic        regwrite_wb;
    logic [31:0] write_data_wb;
`ifdef WB_INSTRET_EN
    logic [IW-1:0] instret;
`endif

    wb_stage #(.INSTRET_WIDTH(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .valid_mem      (valid_mem),
        .rd_mem         (rd_mem),
        .regwrite_mem   (regwrite_mem),
        .memtoreg_mem   (memtoreg_mem),
        .branchjalx_mem (branchjalx_mem),
        .funct3_mem     (funct3_mem),
        .addr_lo_mem    (addr_lo_mem),
        .alu_result_mem (alu_result_mem),
        .pc_plus4_mem   (pc_plus4_mem),
        .read_data_mem  (read_data_mem),
        .rd_wb          (rd_wb),
        .regwrite_wb    (regwrite_wb),
        .write_data_wb  (write_data_wb)
`ifdef WB_INSTRET_EN
        ,
        .instret        (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the WB outputs should show, plus whether a real instruction sits in WB.
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic        exp_we;
    logic [31:0] exp_data;
    int unsigned exp_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural load result from the byte-offset rules, plain integer arithmetic.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] al, input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        int unsigned sh_b;
        int unsigned sh_h;
        sh_b = 8 * int'(al);
        sh_h = al[1] ? 16 : 0;
        b = (w >> sh_b) & 32'hFF;
        h = (w >> sh_h) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic set_instr(input logic v, input logic [4:0] rd, input logic rw, input logic mtr,
                             input logic bj, input logic [2:0] f3, input logic [1:0] al,
                             input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] rdat);
        valid_mem      = v;
        rd_mem         = rd;
        regwrite_mem   = rw;
        memtoreg_mem   = mtr;
        branchjalx_mem = bj;
        funct3_mem     = f3;
        addr_lo_mem    = al;
        alu_result_mem = alu;
        pc_plus4_mem   = pc4;
        read_data_mem  = rdat;
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_rd    = '0;
        exp_we    = 1'b0;
        exp_data  = '0;
        exp_cnt   = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rd"}, 64'(rd_wb), 64'(exp_rd));
        check({tag, ".we"}, 64'(regwrite_wb), 64'(exp_we));
        check({tag, ".data"}, 64'(write_data_wb), 64'(exp_data));
`ifdef WB_INSTRET_EN
        check({tag, ".instret"}, 64'(instret), 64'(exp_cnt % (1 << IW)));
`endif
    endtask

    // One clock edge with the given stall/flush, model update, then output check.
    task automatic step(input string tag, input logic st, input logic fl);
        logic        v;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] d;
        stall = st;
        flush = fl;
        v  = valid_mem;
        rd = rd_mem;
        we = valid_mem && regwrite_mem && (rd_mem != 0);
        if (branchjalx_mem)    d = pc_plus4_mem;
        else if (memtoreg_mem) d = load_val(funct3_mem, addr_lo_mem, read_data_mem);
        else                   d = alu_result_mem;
        @(posedge clk);
        if (exp_valid && (!st || fl)) exp_cnt++;
        if (fl) begin
            exp_valid = 1'b0; exp_rd = '0; exp_we = 1'b0; exp_data = '0;
        end else if (!st) begin
            exp_valid = v; exp_rd = rd; exp_we = we; exp_data = d;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        set_instr(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, 32'hDEAD_BEEF, 32'h4, 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Signed byte load from the top byte.
        set_instr(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 3'd0, 2'd3, 32'h0, 32'h0, 32'h80FF_FF12);
        step("lb_a3", 1'b0, 1'b0);
        check("lb_a3.const", 64'(write_data_wb), 64'hFFFF_FF80);

        set_instr(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'd5, 2'd2, 32'h0, 32'h0, 32'hBEEF_1234);
        step("lhu_a2", 1'b0, 1'b0);
        check("lhu_a2.const", 64'(write_data_wb), 64'h0000_BEEF);
        set_instr(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'd1, 2'd2, 32'h0, 32'h0, 32'hBEEF_1234);
        step("lh_a2", 1'b0, 1'b0);
        check("lh_a2.const", 64'(write_data_wb), 64'hFFFF_BEEF);

        // Jump-and-link: link address beats ALU result; rd=0 suppresses the write.
        set_instr(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 32'h200, 32'h104, 32'h0);
        step("jal_rd1", 1'b0, 1'b0);
        check("jal_rd1.const", 64'(write_data_wb), 64'h104);
        set_instr(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 32'h200, 32'h104, 32'h0);
        step("jal_rd0", 1'b0, 1'b0);
        check("jal_rd0.we", 64'(regwrite_wb), 64'h0);

        // Capture, hold through three stalls while inputs change, then stall+flush.
        set_instr(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
        step("hold_cap", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, $urandom, 32'h0, 32'h0);
            step("hold_stall", 1'b1, 1'b0);
        end
        check("hold_stall.data", 64'(write_data_wb), 64'h1234_5678);
        step("hold_flush", 1'b1, 1'b1);
        check("hold_flush.we", 64'(regwrite_wb), 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_instr(1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom_range(0, 4) == 0), f3_tab[$urandom_range(0, 7)], 2'($urandom),
                      $urandom, $urandom, $urandom);
            step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset in the middle of a stall: outputs clear with no clock edge.
        set_instr(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
        step("pre_rst", 1'b0, 1'b0);
        stall = 1'b1;
        flush = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // Seventeen unstalled retirements: with a 4-bit counter the count wraps to 1.
        for (int i = 0; i < 17; i++) begin
            set_instr(1'b1, 5'($urandom_range(1, 31)), 1'b1, 1'b0, 1'b0, 3'd2, 2'd0, $urandom, 32'h0, 32'h0);
            step("retire", 1'b0, 1'b0);
        end
        set_instr(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0);
        step("retire_last", 1'b0, 1'b0);
`ifdef WB_INSTRET_EN
        check("instret_wrap", 64'(instret), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("instret_rst", 64'(instret), 64'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
